// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: synchronised per-channel interrupt capture with selectable
// trigger mode, software set, lost-event flags, a lowest-index priority
// encoder and a coalesced aggregate request.
module interrupt_ctrl #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int ID_W        = 6
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WIDTH-1:0]     int_src,
  input  logic [2*WIDTH-1:0]   int_mode,
  input  logic [WIDTH-1:0]     int_en,
  input  logic [WIDTH-1:0]     int_set,
  input  logic [WIDTH-1:0]     int_clr,
  input  logic [ID_W:0]        coal_thr,
  input  logic [CNT_W-1:0]     coal_tmo,
  output logic [WIDTH-1:0]     int_sta,
  output logic [WIDTH-1:0]     int_line,
  output logic [WIDTH-1:0]     int_ovf,
  output logic                 irq,
  output logic [ID_W-1:0]      irq_id,
  output logic                 irq_valid
);

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_RISE  = 2'b01;
  localparam logic [1:0] MODE_FALL  = 2'b10;
  localparam logic [1:0] MODE_BOTH  = 2'b11;

  logic [WIDTH-1:0] src_s;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] int_sta_q, int_sta_d;
  logic [WIDTH-1:0] int_ovf_q, int_ovf_d;
  logic [WIDTH-1:0] src_evt, edge_evt;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             irq_q, irq_d;
  logic [CNT_W:0]   timer_inc;
  logic [ID_W:0]    n_act;
  logic             active, thr_hit, tmo_hit;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign src_s = int_src;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;

      // Shift the raw sources one stage further down the synchroniser chain.
      always_comb begin
        sync_d[0] = int_src;
        for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
      end

      // Synchroniser chain; cleared so a source held high through reset is
      // seen as a fresh rising edge once reset is released.
      always_ff @(posedge clk or negedge rstn) begin
        // NOTE: state is only ever updated with <= so every flop samples the
        // pre-edge value of its neighbours, independent of block ordering.
        if (!rstn) sync_q <= '0;
        else       sync_q <= sync_d;
      end

      assign src_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Per-channel event detection and sticky status / overflow next state.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    src_evt  = '0;
    edge_evt = '0;
    prev_d   = src_s;
    for (int i = 0; i < WIDTH; i++) begin
      case (int_mode[2*i +: 2])
        MODE_LEVEL: src_evt[i] = src_s[i];
        MODE_RISE:  src_evt[i] = src_s[i] & ~prev_q[i];
        MODE_FALL:  src_evt[i] = ~src_s[i] & prev_q[i];
        MODE_BOTH:  src_evt[i] = src_s[i] ^ prev_q[i];
      endcase
      // A held level is not a lost event, so only edge modes feed overflow.
      edge_evt[i] = src_evt[i] & (int_mode[2*i +: 2] != MODE_LEVEL);
    end
    // New events win over a coincident clear for both status and overflow.
    int_sta_d = (int_sta_q & ~int_clr) | src_evt | int_set;
    int_ovf_d = (int_ovf_q & ~int_clr) | ((edge_evt | int_set) & int_sta_q);
  end

  assign int_line  = int_sta_q & int_en;
  assign irq_valid = |int_line;

  // Lowest-index active line wins; scanning downward lets lower bits overwrite.
  always_comb begin
    irq_id = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (int_line[i]) irq_id = ID_W'(i);
    end
  end

  // Count active lines for the coalescing threshold.
  always_comb begin
    n_act = '0;
    for (int i = 0; i < WIDTH; i++) n_act = n_act + {{ID_W{1'b0}}, int_line[i]};
  end

  assign active    = irq_valid;
  assign timer_inc = (CNT_W+1)'(timer_q) + (CNT_W+1)'(1);
  assign thr_hit   = active & (n_act >= coal_thr);
  assign tmo_hit   = active & (coal_tmo != '0) & (timer_inc >= {1'b0, coal_tmo});

  // Coalescing timer and aggregate request next state.
  always_comb begin
    timer_d = timer_q;
    irq_d   = irq_q;
    if (!active) begin
      timer_d = '0;
    end else if (!irq_q && (timer_q != '1)) begin
      timer_d = timer_inc[CNT_W-1:0];
    end
    if (thr_hit || tmo_hit) irq_d = 1'b1;
    else if (!active)       irq_d = 1'b0;
  end

  // Edge history, status, overflow, timer and request registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q    <= '0;
      int_sta_q <= '0;
      int_ovf_q <= '0;
      timer_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      int_sta_q <= int_sta_d;
      int_ovf_q <= int_ovf_d;
      timer_q   <= timer_d;
      irq_q     <= irq_d;
    end
  end

  assign int_sta = int_sta_q;
  assign int_ovf = int_ovf_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Testbench for interrupt_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the channel rules.
module tb_interrupt_ctrl;

  localparam int WIDTH = 32;
  localparam int SYNC  = 2;
  localparam int CNT_W = 16;
  localparam int ID_W  = 6;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [WIDTH-1:0]     int_src;
  logic [2*WIDTH-1:0]   int_mode;
  logic [WIDTH-1:0]     int_en;
  logic [WIDTH-1:0]     int_set;
  logic [WIDTH-1:0]     int_clr;
  logic [ID_W:0]        coal_thr;
  logic [CNT_W-1:0]     coal_tmo;
  logic [WIDTH-1:0]     int_sta;
  logic [WIDTH-1:0]     int_line;
  logic [WIDTH-1:0]     int_ovf;
  logic                 irq;
  logic [ID_W-1:0]      irq_id;
  logic                 irq_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  interrupt_ctrl #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .CNT_W(CNT_W), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rstn(rstn), .int_src(int_src), .int_mode(int_mode),
    .int_en(int_en), .int_set(int_set), .int_clr(int_clr),
    .coal_thr(coal_thr), .coal_tmo(coal_tmo), .int_sta(int_sta),
    .int_line(int_line), .int_ovf(int_ovf), .irq(irq), .irq_id(irq_id),
    .irq_valid(irq_valid)
  );

  // Reference model: source history as a delay line of past samples, plus
  // the sticky words and a count of cycles spent waiting with lines active.
  logic [WIDTH-1:0] m_hist [SYNC];
  logic [WIDTH-1:0] m_prev, m_sta, m_ovf;
  bit               m_irq;
  int               m_wait;
  logic [WIDTH-1:0] nx_src, nx_prev, nx_sta, nx_ovf;
  bit               nx_irq;
  int               nx_wait;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
    m_prev = '0; m_sta = '0; m_ovf = '0; m_irq = 0; m_wait = 0;
  endtask

  function automatic int lowest_set(input logic [WIDTH-1:0] v);
    for (int i = 0; i < WIDTH; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_eval();
    logic [WIDTH-1:0] s;
    bit e, ed, fire, act;
    int n;
    s = m_hist[SYNC-1];
    for (int i = 0; i < WIDTH; i++) begin
      case (int_mode[2*i +: 2])
        2'd0:    begin e = s[i];                ed = 0; end
        2'd1:    begin e = s[i] && !m_prev[i];  ed = e; end
        2'd2:    begin e = !s[i] && m_prev[i];  ed = e; end
        default: begin e = (s[i] != m_prev[i]); ed = e; end
      endcase
      nx_sta[i] = e || int_set[i] || (m_sta[i] && !int_clr[i]);
      nx_ovf[i] = ((ed || int_set[i]) && m_sta[i]) || (m_ovf[i] && !int_clr[i]);
    end
    n    = $countones(m_sta & int_en);
    act  = (n > 0);
    fire = act && ((n >= int'(coal_thr)) ||
                   (coal_tmo != 0 && m_wait + 1 >= int'(coal_tmo)));
    if (!act)       nx_wait = 0;
    else if (m_irq) nx_wait = m_wait;
    else            nx_wait = (m_wait < (1 << CNT_W) - 1) ? m_wait + 1 : m_wait;
    nx_irq  = fire ? 1 : (act ? m_irq : 0);
    nx_src  = int_src;
    nx_prev = s;
  endtask

  task automatic model_commit();
    for (int k = SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = nx_src;
    m_prev = nx_prev; m_sta = nx_sta; m_ovf = nx_ovf;
    m_irq = nx_irq; m_wait = nx_wait;
  endtask

  task automatic compare_comb(input string tag);
    logic [WIDTH-1:0] ln;
    ln = m_sta & int_en;
    check({tag, ".line"},  64'(int_line),  64'(ln));
    check({tag, ".id"},    64'(irq_id),    64'(lowest_set(ln)));
    check({tag, ".valid"}, 64'(irq_valid), 64'(ln != 0));
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".sta"}, 64'(int_sta), 64'(m_sta));
    check({tag, ".ovf"}, 64'(int_ovf), 64'(m_ovf));
    check({tag, ".irq"}, 64'(irq),     64'(m_irq));
    compare_comb(tag);
  endtask

  // One clock: model sees the pre-edge inputs, pulses drop, outputs compared.
  task automatic tick(input string tag = "step");
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
    int_set = '0;
    int_clr = '0;
    compare_all(tag);
  endtask

  // Mid-cycle asynchronous reset pulse, released before the next edge.
  task automatic async_reset();
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check("arst.sta",   64'(int_sta),   64'(0));
    check("arst.ovf",   64'(int_ovf),   64'(0));
    check("arst.irq",   64'(irq),       64'(0));
    check("arst.line",  64'(int_line),  64'(0));
    check("arst.valid", 64'(irq_valid), 64'(0));
    #2 rstn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; int_src = '0; int_mode = '0; int_en = '0; int_set = '0;
    int_clr = '0; coal_thr = 7'd1; coal_tmo = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    check("reset.sta", 64'(int_sta), 64'(0));
    check("reset.ovf", 64'(int_ovf), 64'(0));
    check("reset.irq", 64'(irq),     64'(0));
    compare_all("reset");

    // Rising edge on channel 0 through the two-stage synchroniser.
    int_mode[1:0] = 2'b01; int_en[0] = 1'b1; int_src[0] = 1'b1;
    tick("rise"); tick("rise");
    check("rise.early", 64'(int_sta[0]), 64'(0));
    tick("rise");
    check("rise.sta",   64'(int_sta[0]), 64'(1));
    check("rise.valid", 64'(irq_valid),  64'(1));
    check("rise.id",    64'(irq_id),     64'(0));
    repeat (5) tick("rise_hold");
    check("rise.no_ovf",  64'(int_ovf[0]), 64'(0));
    check("rise.sticky",  64'(int_sta[0]), 64'(1));
    int_src[0] = 1'b0; int_clr[0] = 1'b1;
    tick("rise_clr");
    check("rise.cleared", 64'(int_sta[0]), 64'(0));
    repeat (3) tick("idle");

    // Level mode on channel 3: clear is ineffective while the source is high.
    int_en[3] = 1'b1; int_src[3] = 1'b1;
    repeat (3) tick("lvl");
    check("lvl.sta", 64'(int_sta[3]), 64'(1));
    int_clr[3] = 1'b1;
    tick("lvl_clr_hi");
    check("lvl.clr_ignored", 64'(int_sta[3]), 64'(1));
    check("lvl.no_ovf",      64'(int_ovf[3]), 64'(0));
    int_src[3] = 1'b0;
    repeat (3) tick("lvl_drop");
    int_clr[3] = 1'b1;
    tick("lvl_clr_lo");
    check("lvl.cleared", 64'(int_sta[3]), 64'(0));

    // Both-edges channel 5: overflow, set-vs-clear, then a lone clear.
    int_mode[11:10] = 2'b11; int_en[5] = 1'b1; int_src[5] = 1'b1;
    repeat (3) tick("both");
    check("both.sta", 64'(int_sta[5]), 64'(1));
    check("both.ovf0", 64'(int_ovf[5]), 64'(0));
    int_src[5] = 1'b0;
    repeat (3) tick("both2");
    check("both.ovf1", 64'(int_ovf[5]), 64'(1));
    int_src[5] = 1'b1;
    tick("both3"); tick("both3");
    int_clr[5] = 1'b1;
    tick("both_setclr");
    check("setclr.sta", 64'(int_sta[5]), 64'(1));
    check("setclr.ovf", 64'(int_ovf[5]), 64'(1));
    int_clr[5] = 1'b1;
    tick("lone_clr");
    check("loneclr.sta", 64'(int_sta[5]), 64'(0));
    check("loneclr.ovf", 64'(int_ovf[5]), 64'(0));

    // Quiesce sources, then priority among software-set bits.
    int_src = '0;
    repeat (4) tick("quiet");
    int_clr = '1;
    tick("clr_all");
    int_en = '1;
    int_set = (32'd1 << 7) | (32'd1 << 2) | (32'd1 << 30);
    tick("prio");
    check("prio.id", 64'(irq_id), 64'(2));
    int_en[2] = 1'b0;
    #1;
    check("prio.mask_id",   64'(irq_id),   64'(7));
    check("prio.mask_line", 64'(int_line), 64'((32'd1 << 7) | (32'd1 << 30)));
    compare_comb("prio_mask");

    // Coalescing by threshold, no timeout.
    int_en = '1; int_clr = '1; coal_thr = 7'd3; coal_tmo = '0;
    tick("coal_clr"); tick("coal_clr");
    check("coal.idle", 64'(irq), 64'(0));
    int_set = (32'd1 << 1) | (32'd1 << 4);
    tick("coal2");
    repeat (20) tick("coal2_wait");
    check("coal.below_thr", 64'(irq), 64'(0));
    int_set[9] = 1'b1;
    tick("coal3");
    check("coal.lag", 64'(irq), 64'(0));
    tick("coal3");
    check("coal.fire", 64'(irq), 64'(1));
    int_clr = (32'd1 << 1) | (32'd1 << 4) | (32'd1 << 9);
    tick("coal_drop");
    check("coal.hold", 64'(irq), 64'(1));
    tick("coal_drop");
    check("coal.drop", 64'(irq), 64'(0));

    // Coalescing by timeout: request exactly 10 edges after the line rises.
    coal_thr = 7'd8; coal_tmo = 16'd10;
    int_set[12] = 1'b1;
    tick("tmo_start");
    repeat (9) tick("tmo_wait");
    check("tmo.before", 64'(irq), 64'(0));
    tick("tmo_fire");
    check("tmo.fire", 64'(irq), 64'(1));
    int_clr[12] = 1'b1;
    tick("tmo_clr"); tick("tmo_clr");
    int_set[12] = 1'b1;
    tick("tmo_restart");
    repeat (4) tick("tmo_mid");
    async_reset();
    int_set[12] = 1'b1;
    tick("tmo_after_rst");
    repeat (9) tick("tmo_after_rst_wait");
    check("tmo.rst_before", 64'(irq), 64'(0));
    tick("tmo_after_rst_fire");
    check("tmo.rst_fire", 64'(irq), 64'(1));

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        coal_thr = 7'($urandom_range(0, WIDTH + 2));
        coal_tmo = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 24));
      end
      if (c % 40 == 0) int_mode = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) int_en = $urandom;
      int_src = int_src ^ ($urandom & $urandom & $urandom);
      int_set = $urandom & $urandom & $urandom & $urandom;
      int_clr = $urandom & $urandom & $urandom;
      #1;
      compare_comb("rnd_comb");
      tick("rnd");
      if (c % 700 == 350) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
